// File: rtl/reg_file_sb.sv
// Integer register file with NRD read ports, one write port and a
// pending-write scoreboard; a post-reset sweep zeroes the array.
module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic [NRD*AW-1:0] rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]    rs_busy,
  input  logic              reg_write,
  input  logic [AW-1:0]     rd_addr,
  input  logic [XLEN-1:0]   write_data,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic              any_busy
);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [AW-1:0] FIRST = AW'(1);
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

  logic [0:0]       state;
  logic [AW-1:0]    init_cnt;
  logic [NREGS-1:1] pending;
  logic [XLEN-1:0]  mem [1:NREGS-1];

  logic run;
  logic wr_en;
  logic iss_en;

  assign run    = (state == RUN);
  assign wr_en  = run && reg_write && (rd_addr != '0);
  assign iss_en = run && issue_valid && (issue_rd != '0);

  assign ready    = run;
  assign any_busy = |pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= FIRST;
      pending  <= '0;
    end else begin
      unique case (state)
        INIT: begin
          init_cnt <= init_cnt + FIRST;
          if (init_cnt == LAST)
            state <= RUN;
        end
        default: begin
          // Issue is applied last so a new producer wins over the write.
          if (wr_en)
            pending[rd_addr] <= 1'b0;
          if (iss_en)
            pending[issue_rd] <= 1'b1;
        end
      endcase
    end
  end

  // Array has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (!run)
      mem[init_cnt] <= '0;
    else if (wr_en)
      mem[rd_addr] <= write_data;
  end

  logic [AW-1:0] ra;

  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    ra      = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rs_addr[i*AW +: AW];
      if (!run) begin
        rs_busy[i] = 1'b1;
      end else if (ra == '0) begin
        rs_busy[i] = 1'b0;
      end else if (wr_en && (rd_addr == ra)) begin
        rs_data[i*XLEN +: XLEN] = write_data;
      end else begin
        rs_data[i*XLEN +: XLEN] = mem[ra];
        rs_busy[i] = pending[ra];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default instance plus a
// NREGS=16 / NRD=4 / XLEN=64 instance.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // default instance
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] write_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        ready;
  logic        any_busy;

  reg_file_sb dut_a (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .rs_addr     (rs_addr),
    .rs_data     (rs_data),
    .rs_busy     (rs_busy),
    .reg_write   (reg_write),
    .rd_addr     (rd_addr),
    .write_data  (write_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .any_busy    (any_busy)
  );

  // wide instance
  logic [15:0]  b_rs_addr;
  logic [255:0] b_rs_data;
  logic [3:0]   b_rs_busy;
  logic         b_reg_write;
  logic [3:0]   b_rd_addr;
  logic [63:0]  b_write_data;
  logic         b_issue_valid;
  logic [3:0]   b_issue_rd;
  logic         b_ready;
  logic         b_any_busy;

  reg_file_sb #(
    .XLEN  (64),
    .NREGS (16),
    .NRD   (4)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .ready       (b_ready),
    .rs_addr     (b_rs_addr),
    .rs_data     (b_rs_data),
    .rs_busy     (b_rs_busy),
    .reg_write   (b_reg_write),
    .rd_addr     (b_rd_addr),
    .write_data  (b_write_data),
    .issue_valid (b_issue_valid),
    .issue_rd    (b_issue_rd),
    .any_busy    (b_any_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] bval(input int r);
    return {32'hFACE0000 + r, 32'h0BAD0000 + r};
  endfunction

  // count edges until both instances are ready, bounded
  task automatic wait_ready(input string tag);
    int e_a;
    int e_b;
    e_a = 0;
    e_b = 0;
    for (int e = 1; e <= 100; e++) begin
      step();
      if (ready && e_a == 0)
        e_a = e;
      if (b_ready && e_b == 0)
        e_b = e;
      if (e_a != 0 && e_b != 0)
        break;
    end
    chk({tag, "_edges_a"}, e_a, 31);
    chk({tag, "_edges_b"}, e_b, 15);
  endtask

  initial begin
    rst           = 1'b1;
    rs_addr       = {5'd9, 5'd5};
    reg_write     = 1'b0;
    rd_addr       = '0;
    write_data    = '0;
    issue_valid   = 1'b0;
    issue_rd      = '0;
    b_rs_addr     = {4'd4, 4'd3, 4'd2, 4'd1};
    b_reg_write   = 1'b0;
    b_rd_addr     = '0;
    b_write_data  = '0;
    b_issue_valid = 1'b0;
    b_issue_rd    = '0;

    step();
    step();
    chk("rst_ready", ready, 1'b0);
    chk("rst_any_busy", any_busy, 1'b0);
    chk("init_busy", rs_busy, 2'b11);
    chk("init_data", rs_data, 64'h0);
    chk("init_busy_b", b_rs_busy, 4'hF);
    rst = 1'b0;

    wait_ready("boot");

    for (int r = 0; r < 32; r++) begin
      rs_addr = {5'(31 - r), 5'(r)};
      #1;
      chk("zero_data", rs_data, 64'h0);
      chk("zero_busy", rs_busy, 2'b00);
    end

    // write then read
    reg_write  = 1'b1;
    rd_addr    = 5'd5;
    write_data = 32'hDEADBEEF;
    step();
    rd_addr    = 5'd0;
    write_data = 32'h12345678;
    rs_addr    = {5'd0, 5'd5};
    step();
    reg_write  = 1'b0;
    #1;
    chk("x5_read", rs_data[31:0], 32'hDEADBEEF);
    chk("x0_data", rs_data[63:32], 32'h0);
    chk("x0_busy", rs_busy[1], 1'b0);

    // bypass on a pending register
    reg_write  = 1'b1;
    rd_addr    = 5'd7;
    write_data = 32'h1;
    step();
    reg_write   = 1'b0;
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    step();
    issue_valid = 1'b0;
    rs_addr     = {5'd7, 5'd5};
    #1;
    chk("x7_old", rs_data[63:32], 32'h1);
    chk("x7_pend", rs_busy[1], 1'b1);
    reg_write  = 1'b1;
    write_data = 32'hA5A5A5A5;
    #1;
    chk("byp_data", rs_data[63:32], 32'hA5A5A5A5);
    chk("byp_busy", rs_busy, 2'b00);
    chk("byp_other", rs_data[31:0], 32'hDEADBEEF);
    step();
    reg_write = 1'b0;
    #1;
    chk("x7_new", rs_data[63:32], 32'hA5A5A5A5);
    chk("x7_idle", any_busy, 1'b0);

    // scoreboard
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    step();
    issue_valid = 1'b0;
    rs_addr     = {5'd5, 5'd9};
    #1;
    chk("x9_busy", rs_busy[0], 1'b1);
    chk("x9_any", any_busy, 1'b1);
    reg_write  = 1'b1;
    rd_addr    = 5'd9;
    write_data = 32'h99;
    step();
    reg_write = 1'b0;
    #1;
    chk("x9_clr", rs_busy[0], 1'b0);
    chk("x9_data", rs_data[31:0], 32'h99);
    chk("x9_any0", any_busy, 1'b0);
    reg_write   = 1'b1;
    write_data  = 32'h100;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    step();
    reg_write   = 1'b0;
    issue_valid = 1'b0;
    #1;
    chk("wi_busy", rs_busy[0], 1'b1);
    chk("wi_data", rs_data[31:0], 32'h100);
    reg_write   = 1'b1;
    write_data  = 32'h200;
    issue_valid = 1'b1;
    issue_rd    = 5'd10;
    step();
    reg_write   = 1'b0;
    issue_valid = 1'b0;
    rs_addr     = {5'd10, 5'd9};
    #1;
    chk("diff_busy", rs_busy, 2'b10);
    chk("diff_data", rs_data[31:0], 32'h200);

    // mid-run reset
    reg_write   = 1'b1;
    rd_addr     = 5'd3;
    write_data  = 32'h55;
    step();
    reg_write   = 1'b0;
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    step();
    issue_valid = 1'b0;
    rs_addr     = {5'd4, 5'd3};
    #1;
    chk("x3_pend", rs_busy, 2'b01);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_ready", ready, 1'b0);
    chk("mid_any", any_busy, 1'b0);
    reg_write   = 1'b1;
    rd_addr     = 5'd3;
    write_data  = 32'hFF;
    issue_valid = 1'b1;
    issue_rd    = 5'd4;
    #1;
    rst = 1'b0;
    wait_ready("rerun");
    reg_write   = 1'b0;
    issue_valid = 1'b0;
    #1;
    chk("x3_zero", rs_data[31:0], 32'h0);
    chk("x34_busy", rs_busy, 2'b00);
    chk("rerun_any", any_busy, 1'b0);

    // wide instance
    b_reg_write = 1'b1;
    for (int r = 1; r < 16; r++) begin
      b_rd_addr    = 4'(r);
      b_write_data = bval(r);
      step();
    end
    b_reg_write = 1'b0;
    b_rs_addr   = {4'd0, 4'd3, 4'd7, 4'd12};
    #1;
    chk("b_p0", b_rs_data[63:0], bval(12));
    chk("b_p1", b_rs_data[127:64], bval(7));
    chk("b_p2", b_rs_data[191:128], bval(3));
    chk("b_p3", b_rs_data[255:192], 64'h0);
    chk("b_busy", b_rs_busy, 4'h0);
    for (int p = 0; p < 4; p++) begin
      b_rs_addr = {4'd4, 4'd3, 4'd2, 4'd1};
      b_rs_addr[p*4 +: 4] = 4'd14;
      b_reg_write  = 1'b1;
      b_rd_addr    = 4'd14;
      b_write_data = 64'h0123456789ABCDE0 + 64'(p);
      #1;
      for (int q = 0; q < 4; q++) begin
        if (q == p)
          chk("b_byp", b_rs_data[q*64 +: 64], b_write_data);
        else
          chk("b_other", b_rs_data[q*64 +: 64], bval(q + 1));
      end
      step();
      b_reg_write = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the integer register file, used by the decode/issue stage of the pipelined core. It has NRD combinational read ports and one synchronous write port, with write-through bypass. A per-register pending-write scoreboard lets issue logic detect RAW hazards. A post-reset init sweep zeroes the array one entry per cycle, so the storage can map onto RAM-style resources without a parallel clear.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, architectural register count; power of two, >= 4
NRD, 2, number of read ports, 1..4
AW, $clog2(NREGS), address width; derived, never overridden

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-high
ready  output  1  high once the init sweep is done; writes and issues are honoured only while high
rs_addr  input  NRD*AW  read addresses; port i at bits [i*AW +: AW]
rs_data  output  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN]
rs_busy  output  NRD  port i's register has a pending write
reg_write  input  1  write enable
rd_addr  input  AW  write address
write_data  input  XLEN  write data
issue_valid  input  1  an instruction targeting issue_rd is issued this cycle
issue_rd  input  AW  destination register of the issuing instruction
any_busy  output  1  OR of all scoreboard bits

Behaviour:
- Storage: entries 1..NREGS-1 of XLEN bits. Register 0 is not stored.
- Scoreboard: pending[1..NREGS-1], one bit per register.
- FSM states: INIT and RUN.
- Reset (async, while rst=1):
  - state=INIT, init counter=1, all pending bits cleared.
  - ready=0, any_busy=0.
  - Array contents are not reset directly.
- INIT:
  - Each rising edge writes 0 to mem[counter] and increments the counter.
  - The edge that writes entry NREGS-1 moves the state to RUN.
  - ready goes high after exactly NREGS-1 rising edges following rst deassertion (31 for the default).
  - While in INIT: rs_data reads 0 on all ports, rs_busy is all-ones, and reg_write and issue_valid are ignored.
- rst asserted mid-sweep or in RUN: immediate return to INIT with counter=1 and pending cleared. The sweep restarts in full.
- RUN, reads (combinational, zero latency), for each port i:
  - rs_addr_i==0: rs_data_i=0, rs_busy_i=0.
  - reg_write=1 and rd_addr==rs_addr_i!=0: rs_data_i=write_data (bypass) and rs_busy_i=0, even if the register is pending.
  - Otherwise: rs_data_i=mem[rs_addr_i] and rs_busy_i=pending[rs_addr_i].
  - The bypass/busy decision does not depend on issue_valid in the same cycle.
- RUN, write:
  - reg_write=1 and rd_addr!=0: mem[rd_addr]<=write_data and pending[rd_addr]<=0.
  - Writes to register 0 are discarded.
  - A write to a non-pending register is legal and updates only the data.
- RUN, issue:
  - issue_valid=1 and issue_rd!=0: pending[issue_rd]<=1.
  - issue_rd==0 is ignored.
- Simultaneous write and issue to the same register in one cycle: issue wins, so pending ends up 1 (new producer). The data is still written.
- Simultaneous write and issue to different registers: both take effect.
- any_busy is registered-state derived: the OR of pending after the edge, with no same-cycle bypass.
- Widths are exact. No sign or zero extension anywhere.

Test Plan:
- Reset release: count edges until ready rises.
  - Expect ready=1 after exactly 31 edges (default parameters).
  - Every register reads 0 with rs_busy=0.
  - During INIT, rs_busy=2'b11.
- Write then read: write x5=0xDEADBEEF, then read port0=x5 next cycle.
  - Expect 0xDEADBEEF.
  - Write x0=0x12345678: x0 reads 0 afterwards.
- Bypass: in one cycle, reg_write with rd=7, write_data=0xA5A5A5A5, and port1 reading x7 (old value 0x1).
  - Expect rs_data port1=0xA5A5A5A5 and rs_busy=0 in that same cycle.
- Scoreboard: issue rd=9, then read x9.
  - Expect rs_busy=1 and any_busy=1.
  - Write x9: busy drops the next cycle and any_busy=0.
  - Same-cycle write and issue to x9: rs_busy stays 1 after the edge.
- Mid-run reset: with x3=0x55 pending, pulse rst asynchronously between edges.
  - Expect ready=0 and any_busy=0 immediately.
  - After 31 edges, x3 reads 0 and writes issued during INIT have no effect.
- Parameter sweep: NREGS=16, NRD=4, XLEN=64.
  - ready after 15 edges.
  - Four ports read distinct registers independently, with bypass on each port.
